// File: rtl/psum_drain_quant.sv
// Snapshots the array's column sums on a completed tile, requantizes each word
// (round, shift, optional ReLU, saturate) and streams one column per handshake.
module psum_drain_quant #(
  parameter int ARRAY_SIZE = 4,
  parameter int DATA_W     = 32,
  parameter int OUT_W      = 8,
  parameter int COL_W      = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1
) (
  input  logic                                clk,
  input  logic                                nRST,
  input  logic [ARRAY_SIZE-1:0][DATA_W-1:0]   acc_in,
  input  logic                                acc_valid,
  input  logic [4:0]                          shift_amt,
  input  logic                                relu_en,
  output logic signed [OUT_W-1:0]             out_data,
  output logic [COL_W-1:0]                    out_col,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_last,
  output logic                                busy,
  output logic                                drop_err,
  input  logic                                err_clr
);

  typedef enum logic {IDLE, DRAIN} state_t;

  localparam logic [COL_W-1:0]      LAST_COL = COL_W'(ARRAY_SIZE - 1);
  localparam logic signed [DATA_W:0] ONE     = (DATA_W+1)'(1);
  localparam logic signed [DATA_W:0] SAT_MAX = (DATA_W+1)'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [DATA_W:0] SAT_MIN = -SAT_MAX - ONE;

  state_t                           state, state_next;
  logic [COL_W-1:0]                 col, col_next;
  logic [ARRAY_SIZE-1:0][DATA_W-1:0] snap;
  logic [4:0]                       shift_q;
  logic                             relu_q;
  logic                             capture, drop, fire, at_last;

  logic signed [DATA_W:0]           xe, rnd, y;
  logic signed [OUT_W-1:0]          sat;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    col_next   = col;
    capture    = 1'b0;
    drop       = 1'b0;
    fire       = (state == DRAIN) && out_ready;
    at_last    = (col == LAST_COL);
    unique case (state)
      IDLE: begin
        if (acc_valid) begin
          capture    = 1'b1;
          state_next = DRAIN;
          col_next   = '0;
        end
      end
      DRAIN: begin
        // Only the final handshake may absorb a new snapshot; anything else is dropped.
        if (fire && at_last) begin
          col_next = '0;
          if (acc_valid) capture    = 1'b1;
          else           state_next = IDLE;
        end else begin
          if (fire)      col_next = col + 1'b1;
          if (acc_valid) drop     = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      col      <= '0;
      snap     <= '0;
      shift_q  <= '0;
      relu_q   <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      col <= col_next;
      if (capture) begin
        snap    <= acc_in;
        shift_q <= shift_amt;
        relu_q  <= relu_en;
      end
      if (drop)         drop_err <= 1'b1;
      else if (err_clr) drop_err <= 1'b0;
    end
  end

  // One extra bit of headroom keeps the rounding add from overflowing.
  always_comb begin
    xe  = {snap[col][DATA_W-1], snap[col]};
    rnd = '0;
    y   = xe;
    if (32'(shift_q) >= 32'(DATA_W)) begin
      y = '0;
    end else if (shift_q != '0) begin
      rnd = ONE <<< (shift_q - 5'd1);
      y   = (xe + rnd) >>> shift_q;
    end
    if (relu_q && y[DATA_W]) y = '0;
    if (y > SAT_MAX)      sat = SAT_MAX[OUT_W-1:0];
    else if (y < SAT_MIN) sat = SAT_MIN[OUT_W-1:0];
    else                  sat = y[OUT_W-1:0];
  end

  assign out_valid = (state == DRAIN);
  assign busy      = (state == DRAIN);
  assign out_last  = (state == DRAIN) && at_last;
  assign out_col   = col;
  assign out_data  = (state == DRAIN) ? sat : '0;

endmodule
